// File: rtl/wide_add_sequencer_pkg.sv
// wide_add_sequencer_pkg: state encoding and width derivations shared by the wide adder sequencer
package wide_add_sequencer_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int total_w(input int w, input int c);
    return w * c;
  endfunction
  function automatic int idx_w(input int c);
    return $clog2(c);
  endfunction
endpackage

// File: rtl/wide_add_sequencer_adder.sv
// wide_add_sequencer_adder: N-bit adder, full or half, with optional output register
module wide_add_sequencer_adder #(
  parameter int WIDTH = 4,
  parameter bit PIPELINE_ENABLE = 0,
  parameter bit USE_FULL_ADDER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic             w_cin;
  logic [WIDTH:0]   w_full;
  logic             w_unused;
  assign w_cin    = USE_FULL_ADDER ? cin : 1'b0;
  assign w_full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_unused = &{1'b0, clk, rst};
  generate
    if (PIPELINE_ENABLE) begin : g_pipe
      logic [WIDTH:0] r_full;
      // registered result when pipelining is requested
      always_ff @(posedge clk)
        r_full <= rst ? '0 : w_full;
      assign {cout, sum} = r_full;
    end else begin : g_comb
      assign {cout, sum} = w_full;
    end
  endgenerate
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: word-serial wide adder feeding one WIDTH-bit chunk per cycle through a narrow adder
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH*CHUNKS-1:0] a_in,
  input  logic [WIDTH*CHUNKS-1:0] b_in,
  input  logic                    cin_in,
  output logic                    ready,
  output logic                    done,
  output logic [WIDTH*CHUNKS-1:0] sum_out,
  output logic                    cout_out
);
  localparam int TOTAL = total_w(WIDTH, CHUNKS);
  localparam int IDX_W = idx_w(CHUNKS);
  logic [1:0]       r_state, w_next;
  logic [TOTAL-1:0] r_a, r_b, r_partial;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             w_last, w_cout;
  logic [WIDTH-1:0] w_sum;
  assign w_last = r_idx == IDX_W'(CHUNKS - 1);
  wide_add_sequencer_adder #(
    .WIDTH(WIDTH),
    .PIPELINE_ENABLE(1'b0),
    .USE_FULL_ADDER(1'b1)
  ) u_adder (
    .clk (clk),
    .rst (1'b0),
    .a   (r_a[r_idx*WIDTH +: WIDTH]),
    .b   (r_b[r_idx*WIDTH +: WIDTH]),
    .cin (r_carry),
    .sum (w_sum),
    .cout(w_cout)
  );
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  // next-state decode
  always_comb
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  // handshake outputs decoded straight from the state register
  always_comb begin
    ready = r_state == IDLE;
    done  = r_state == DONE;
  end
  // operand capture, chunk accumulation and result load on the final chunk
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_partial <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a     <= a_in;
      r_b     <= b_in;
      r_carry <= cin_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_partial[r_idx*WIDTH +: WIDTH] <= w_sum;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        sum_out  <= {w_sum, r_partial[TOTAL-WIDTH-1:0]};
        cout_out <= w_cout;
      end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed and random self-checking bench for the wide adder sequencer
module tb_wide_add_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        cin_in = 1'b0;
  logic        ready, done, cout_out;
  logic [15:0] sum_out;
  int          total = 0;
  int          passed = 0;
  wide_add_sequencer #(.WIDTH(4), .CHUNKS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .ready(ready), .done(done), .sum_out(sum_out), .cout_out(cout_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
    logic [16:0] exp;
    int n;
    exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    n = 0;
    while (!ready && n < 20) begin tick(); n++; end
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_sum"}, {15'd0, cout_out, sum_out}, {15'd0, exp});
  endtask
  initial begin
    int lowcnt;
    logic sawdone;
    logic [15:0] ra, rb;
    logic rc;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {15'd0, cout_out, sum_out}, 32'd0);
    #10 rst = 1'b1;
    tick();
    // op1: latency and ready-low window
    a_in = 16'h00FF; b_in = 16'h0001; cin_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    lowcnt = 1;
    check("op1_ready_low", {31'd0, ready}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      lowcnt += !ready;
      check("op1_no_early_done", {31'd0, done}, 32'd0);
    end
    tick();
    lowcnt += !ready;
    check("op1_done_e4", {31'd0, done}, 32'd1);
    check("op1_sum", {15'd0, cout_out, sum_out}, 32'h0100);
    tick();
    check("op1_done_clear", {31'd0, done}, 32'd0);
    check("op1_ready_back", {31'd0, ready}, 32'd1);
    check("op1_ready_low_cycles", lowcnt, 5);
    // op2: carry ripples through every chunk
    do_op(16'hFFFF, 16'h0000, 1'b1, "op2");
    check("op2_exact", {15'd0, cout_out, sum_out}, 32'h10000);
    tick();
    // op3: previous result held during RUN
    a_in = 16'h1234; b_in = 16'h4321; cin_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("op3_prev_held", {15'd0, cout_out, sum_out}, 32'h10000);
    end
    tick();
    check("op3_done", {31'd0, done}, 32'd1);
    check("op3_sum", {15'd0, cout_out, sum_out}, 32'h05555);
    tick();
    // op4: start held high, operands changed mid-RUN
    a_in = 16'h1111; b_in = 16'h2222; cin_in = 1'b0; start = 1'b1;
    tick();
    tick();
    tick();
    a_in = 16'hAAAA; b_in = 16'h5555;
    tick();
    tick();
    check("op4_first_done", {31'd0, done}, 32'd1);
    check("op4_first_sum", {15'd0, cout_out, sum_out}, 32'h03333);
    tick();
    check("op4_idle_after_done", {31'd0, ready}, 32'd1);
    tick();
    check("op4_second_accept", {31'd0, ready}, 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("op4_second_done", {31'd0, done}, 32'd1);
    check("op4_second_sum", {15'd0, cout_out, sum_out}, 32'h0FFFF);
    tick();
    // op5: asynchronous reset mid-RUN
    a_in = 16'h1111; b_in = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("async_ready", {31'd0, ready}, 32'd1);
    check("async_done", {31'd0, done}, 32'd0);
    check("async_sum", {15'd0, cout_out, sum_out}, 32'd0);
    tick();
    #3 rst = 1'b1;
    sawdone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sawdone |= done;
    end
    check("abandoned_no_done", {31'd0, sawdone}, 32'd0);
    do_op(16'h8000, 16'h8000, 1'b0, "post_rst");
    check("post_rst_exact", {15'd0, cout_out, sum_out}, 32'h10000);
    // back-to-back random operations
    for (int i = 0; i < 50; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      do_op(ra, rb, rc, $sformatf("rand%0d", i));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Word-serial wide adder controller that sits directly around the team's N-bit adder.
- Accepts two TOTAL-bit operands (TOTAL = WIDTH*CHUNKS) plus carry-in on a start/ready handshake.
- Each cycle it feeds one WIDTH-bit chunk, LSB chunk first, into a single WIDTH-bit adder, with the carry chained through a register.
- Collects the sum chunks and presents the registered TOTAL-bit result with a one-cycle done pulse.
- Lets the downstream datapath do wide additions with one narrow adder instance.

Parameters:
- WIDTH, 4, bit width of one chunk and of the adder instance; must be >= 1.
- CHUNKS, 4, number of chunks per operand; must be >= 2.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on a rising edge where ready=1.
- a_in  in  WIDTH*CHUNKS  operand A; sampled only on the accept edge.
- b_in  in  WIDTH*CHUNKS  operand B; sampled only on the accept edge.
- cin_in  in  1  carry-in to chunk 0; sampled only on the accept edge.
- ready  out  1  high exactly while state is IDLE.
- done  out  1  one-cycle pulse; sum_out and cout_out are valid while it is high.
- sum_out  out  WIDTH*CHUNKS  registered result; held until the next completion.
- cout_out  out  1  carry out of the top chunk; held with sum_out.

Behaviour:
- Reset (rst=0, asynchronous, any state): state=IDLE, ready=1, done=0, sum_out=0, cout_out=0.
  - Internal operand, partial-sum, carry and index registers are also cleared.
  - An operation in flight is abandoned; done never pulses for it.
- States:
  - IDLE: ready=1. On start=1, capture a_in, b_in, set carry_reg=cin_in and idx=0, go to RUN.
  - RUN: ready=0. Each edge does the following:
    - partial[idx*WIDTH +: WIDTH] <= adder sum of a_reg chunk idx, b_reg chunk idx and carry_reg.
    - carry_reg <= adder cout; idx <= idx+1.
    - When idx==CHUNKS-1, this edge also loads sum_out from partial with the final chunk merged in, loads cout_out from the adder cout, and moves to DONE.
  - DONE: done=1, ready=0. The next edge goes to IDLE unconditionally.
- Latency:
  - Accept edge E; RUN occupies edges E+1 .. E+CHUNKS.
  - done is high between edge E+CHUNKS and E+CHUNKS+1.
  - ready returns high after edge E+CHUNKS+1.
  - Throughput is one operation per CHUNKS+2 cycles.
- start while ready=0 is ignored. No queuing; the input operands may change freely.
- sum_out/cout_out change only on the completion edge. The previous result stays stable during RUN.
- Arithmetic is modulo 2^TOTAL. cout_out is bit TOTAL of a+b+cin, i.e. the exact unsigned result is {cout_out, sum_out}.
- The chunk adder is combinational: it is an instance of the N-bit adder with PIPELINE_ENABLE=0 and USE_FULL_ADDER=1. Its own active-high reset is tied inactive (0); its clock is tied to clk.
- done and ready are decoded directly from the state register (glitch-free, no combinational path from inputs).

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, RUN, DONE (2-bit);
  - the TOTAL width derivation;
  - the index width rule IDX_W = $clog2(CHUNKS).
- One sub-module: the existing N-bit parameterized full/half adder, instantiated once as the chunk adder with WIDTH passed through.
- No other hierarchy.

Test Plan (WIDTH=4, CHUNKS=4, TOTAL=16):
- a=0x00FF, b=0x0001, cin=0 -> sum_out=0x0100, cout_out=0; done exactly 4 edges after the accept edge; ready low for 5 cycles.
- a=0xFFFF, b=0x0000, cin=1 -> sum_out=0x0000, cout_out=1 (carry rippled through all chunks).
- a=0x1234, b=0x4321, cin=0 -> sum_out=0x5555, cout_out=0; previous result stays visible on sum_out until the completion edge.
- Hold start=1 through a busy operation and change a_in/b_in to 0xAAAA/0x5555 mid-RUN:
  - the first result is unaffected;
  - the new operands are accepted only on the first edge with ready=1;
  - the second result is 0xFFFF, cout_out=0.
- Drive rst=0 during RUN (after 2 chunks):
  - immediately ready=1, done=0, sum_out=0, cout_out=0, with no clock edge needed;
  - no done pulse follows;
  - after release, 0x8000+0x8000 cin=0 -> sum_out=0x0000, cout_out=1.
- 50 random {a,b,cin} back-to-back -> each done pulse matches {cout_out,sum_out}=a+b+cin; report any mismatch; then print completion.
